// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle between operand fetch, alu_pipe and writeback.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, single output register and ZCVE flags.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier on opcode B.
module alu_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpNot  = 4'h2;
  localparam logic [3:0] OpSll  = 4'h3;
  localparam logic [3:0] OpSrl  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpSltu = 4'h7;
  localparam logic [3:0] OpSra  = 4'h8;
  localparam logic [3:0] OpXor  = 4'h9;
  localparam logic [3:0] OpSlt  = 4'hA;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept;
  logic             load_alu;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_err;

`ifdef ALU_MUL_EN
  localparam logic [3:0]  OpMul = 4'hB;
  localparam int unsigned CntW  = $clog2(WIDTH) + 1;

  typedef enum logic {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign bus.in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  // Single-cycle datapath, evaluated straight from the bus operands.
  always_comb begin
    add_full  = {1'b0, bus.a} + {1'b0, bus.b};
    sub_full  = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (bus.op)
      OpAdd: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpNot:  alu_res = ~bus.a;
      // Shifts by the full b: amounts >= WIDTH yield 0 or all sign bits.
      OpSll:  alu_res = bus.a << bus.b;
      OpSrl:  alu_res = bus.a >> bus.b;
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OpSra:  alu_res = $unsigned($signed(bus.a) >>> bus.b);
      OpXor:  alu_res = bus.a ^ bus.b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    load_alu    = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      StIdle: begin
        if (accept && (bus.op == OpMul)) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = CntW'(WIDTH);
          state_d  = StMul;
        end else begin
          load_alu = accept;
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        // The last partial product is folded in on the same edge the result is written.
        if (cnt_q == CntW'(1)) begin
          result_d    = acc_step;
          zero_d      = (acc_step == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`else
    load_alu = accept;
`endif

    if (load_alu) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      carry_d     = alu_carry;
      ovf_d       = alu_ovf;
      err_d       = alu_err;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected responses, a monitor
// pops and compares on every output transfer. MUL checks run when ALU_MUL_EN is defined.
module tb_alu_pipe;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    logic         e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t  sb_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: an output transfer happens on the next rising edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got %h, expected no output", bus.result);
      end else begin
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, {bus.result, bus.zero, bus.carry, bus.overflow, bus.err}, e);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e, input bit push);
    int budget;
    bit ok;
    budget = 100;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      budget--;
    end
    if (ok && push) begin
      sb_q.push_back(e);
      name_q.push_back(nm);
    end
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_accept: got in_ready=0 for 100 cycles, expected 1", nm);
    end
  endtask

  task automatic run1(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input exp_t e);
    issue(nm, op, a, b, e, 1'b1);
    chk({nm, "_latency"}, bus.out_valid, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 4'h0;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result",    bus.result,    16'h0000);
    chk("rst_zero",      bus.zero,      1'b0);
    chk("rst_carry",     bus.carry,     1'b0);
    chk("rst_overflow",  bus.overflow,  1'b0);
    chk("rst_err",       bus.err,       1'b0);
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //                                              result    z     c     o     e
    run1("add_wrap",   4'h0, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
    run1("add_ovf",    4'h0, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b0, 1'b1, 1'b0});
    run1("sub_ovf",    4'h1, 16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0});
    run1("sub_borrow", 4'h1, 16'h0001, 16'h0002, {16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
    run1("not",        4'h2, 16'h1234, 16'h0000, {16'hEDCB, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("sll_big",    4'h3, 16'h0001, 16'd16,   {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    run1("sll_3",      4'h3, 16'h0001, 16'd3,    {16'h0008, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("srl_4",      4'h4, 16'h8000, 16'd4,    {16'h0800, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("and",        4'h5, 16'hF0F0, 16'h3C3C, {16'h3030, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("or",         4'h6, 16'hF0F0, 16'h3C3C, {16'hFCFC, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("sltu",       4'h7, 16'hFFFF, 16'h0001, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
    run1("sra_big",    4'h8, 16'h8000, 16'd20,   {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("sra_4",      4'h8, 16'h8000, 16'd4,    {16'hF800, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("xor",        4'h9, 16'h00FF, 16'h0F0F, {16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("slt",        4'hA, 16'hFFFF, 16'h0001, {16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
    run1("illegal_e",  4'hE, 16'h1234, 16'h5678, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    run1("illegal_f",  4'hF, 16'hFFFF, 16'hFFFF, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});

    // Back-pressure: first result must hold while later ADDs wait at the input.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    run1("bp_add1", 4'h0, 16'h0001, 16'h0001, {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
    bus.in_valid = 1'b1;
    bus.op = 4'h0;
    bus.a  = 16'h0003;
    bus.b  = 16'h0004;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready,  1'b0);
      chk("bp_hold",     bus.result,    16'h0002);
      chk("bp_valid",    bus.out_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue("bp_add2", 4'h0, 16'h0003, 16'h0004, {16'h0007, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    issue("bp_add3", 4'h0, 16'h1000, 16'h2000, {16'h3000, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    issue("bp_add4", 4'h0, 16'hFFFE, 16'h0003, {16'h0001, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);

`ifdef ALU_MUL_EN
    issue("mul", 4'hB, 16'h0123, 16'h0010, {16'h1230, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("mul_busy_in_ready",  bus.in_ready,  1'b0);
      chk("mul_busy_out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("mul_done_valid", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;

    issue("mul_abort", 4'hB, 16'h0123, 16'h0010, {16'h1230, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_in_ready",  bus.in_ready,  1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("abort_idle_valid", bus.out_valid, 1'b0);
    chk("abort_idle_ready", bus.in_ready,  1'b1);
    run1("post_abort_add", 4'h0, 16'h0010, 16'h0020, {16'h0030, 1'b0, 1'b0, 1'b0, 1'b0});
`else
    run1("opb_illegal", 4'hB, 16'h0123, 16'h0010, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the 16-bit combinational ALU in the execute stage. Operands and opcode are accepted through a valid/ready handshake. Results come out of a single output register with zero/carry/overflow/error flags. The opcode space grows to 4 bits, adding XOR, arithmetic shift right, signed compare and an optional iterative shift-add multiplier. The block sits between the decode/operand-fetch stage and writeback and tolerates writeback back-pressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width (≥4, power of two)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block can accept; combinational
- op  in  4  operation select
- a  in  WIDTH  source 1
- b  in  WIDTH  source 2
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- carry  out  1  ADD carry-out / SUB borrow; else 0
- overflow  out  1  signed overflow for ADD/SUB; else 0
- err  out  1  illegal opcode (or MUL when compiled out)

## Operation
- Opcodes:
  - 0 ADD a+b; 1 SUB a−b; 2 NOT ~a; 3 SLL a<<b; 4 SRL a>>b.
  - 5 AND; 6 OR; 7 SLTU (unsigned a<b → 1 else 0).
  - 8 SRA (sign-fill); 9 XOR; A SLT (signed a<b → 1 else 0).
  - B MUL (low WIDTH bits of a*b).
  - C–F illegal: result=0, err=1, zero=1.
- Shift amount is the full b value. If b ≥ WIDTH: SLL/SRL give 0; SRA gives all copies of a[WIDTH-1].
- ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = operand signs equal and result sign differs.
- SUB: carry = borrow (a < b unsigned). overflow = operand signs differ and result sign differs from a.
- All other ops: carry=0, overflow=0. zero is always computed from the registered result.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready. Output transfer occurs on out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This gives back-to-back throughput of 1/cycle for single-cycle ops.
- FSM:
  - IDLE: on accept of a single-cycle op, register result and flags, set out_valid, stay IDLE. On accept of MUL, latch a, b, clear accumulator, load bit counter = WIDTH, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left and multiplier right; decrement counter. When counter reaches 1, register the accumulator as result, set out_valid, go to IDLE.
- Output register (result + flags) holds stable while out_valid && !out_ready. out_valid clears on the output transfer unless a new accept happens on the same edge, in which case it stays 1 with new data.
- Inputs are ignored when in_ready=0 and are never latched except on accept.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, out_valid=0, result=0, zero=0, carry=0, overflow=0, err=0. in_ready reads 1.
- Single-cycle ops: accept on edge N → out_valid=1 after edge N.
- MUL: accept on edge N → out_valid=1 after edge N+WIDTH. in_ready=0 for those WIDTH cycles.
- Reset asserted mid-MUL aborts the multiply: no result is produced and out_valid=0.
- Simultaneous output drain and new accept on one edge is legal and loses no data.

## Configuration
- ALU_MUL_EN defined: MUL datapath and MUL state are compiled in as above.
- ALU_MUL_EN undefined: no multiplier logic and no MUL state. Opcode B behaves as illegal: single-cycle, result=0, zero=1, err=1.

## Test plan
- ADD a=0xFFFF b=0x0001 (WIDTH=16) → result 0x0000, zero=1, carry=1, overflow=0, out_valid one cycle after accept.
- SUB a=0x8000 b=0x0001 → 0x7FFF, overflow=1, carry=0. SUB a=0x0001 b=0x0002 → 0xFFFF, carry=1.
- SRA a=0x8000 b=20 → 0xFFFF. SLL a=0x0001 b=16 → 0x0000, zero=1. SLT 0xFFFF,0x0001 → 1. SLTU same operands → 0.
- MUL 0x0123×0x0010 (ALU_MUL_EN) → 0x1230 after 16 cycles with in_ready=0 throughout. Repeat with rst_n pulsed low at cycle 8 → out_valid stays 0 and FSM is back in IDLE.
- Back-pressure: 4 back-to-back ADDs with out_ready low for 5 cycles → first result held stable, in_ready=0 until drained, all 4 results delivered in order with no loss.
- Illegal op 0xE → result 0, err=1, zero=1. Without ALU_MUL_EN, op 0xB → same response.
